// File: rtl/tick_scheduler.sv
// Per-channel programmable clock-enable generator. Divisor writes go through a
// two-state handshake: IDLE captures the write, APPLY commits it on the next cycle.
module tick_scheduler #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CW          = 20,
  parameter int unsigned DEFAULT_DIV = 524288,
  localparam int unsigned CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic [NCH-1:0] ch_en,
  input  logic           sync_req,
  output logic [NCH-1:0] tick
);

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t         state;
  logic [CHW-1:0] cap_ch;
  logic [CW-1:0]  cap_div;
  logic [CW-1:0]  div_reg [NCH];
  logic [CW-1:0]  cnt     [NCH];
  logic [CW-1:0]  last    [NCH];
  logic [NCH-1:0] hit;

  // cfg_ready is a pure decode of the state flop
  assign cfg_ready = (state == IDLE);

  // Terminal count per channel; a stored divisor of 0 behaves as 1
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      last[i] = (div_reg[i] == '0) ? '0 : div_reg[i] - CW'(1);
    end
  end

  // Channel targeted by the write being committed this cycle
  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = (state == APPLY) && (cap_ch == CHW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cap_ch  <= '0;
      cap_div <= '0;
      tick    <= '0;
      for (int i = 0; i < NCH; i++) begin
        div_reg[i] <= CW'(DEFAULT_DIV);
        cnt[i]     <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            cap_ch  <= cfg_ch;
            cap_div <= cfg_div;
            state   <= APPLY;
          end
        end
        APPLY:   state <= IDLE;
        default: state <= IDLE;
      endcase

      for (int i = 0; i < NCH; i++) begin
        if (hit[i]) begin
          div_reg[i] <= cap_div;
        end
        // Clearing on load keeps a lowered divisor from skipping its wrap
        if (sync_req || hit[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
        end else if (ch_en[i]) begin
          if (cnt[i] >= last[i]) begin
            cnt[i]  <= '0;
            tick[i] <= 1'b1;
          end else begin
            cnt[i]  <= cnt[i] + CW'(1);
            tick[i] <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: vector table plus hand-built sequences,
// with expected outputs queued at drive time and compared after each clock edge.
module tb_tick_scheduler;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 20;
  localparam int unsigned CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [NCH-1:0] ch_en;
  logic           sync_req;
  logic [NCH-1:0] tick;

  tick_scheduler #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(524288)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .ch_en     (ch_en),
    .sync_req  (sync_req),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           v;
    logic [CHW-1:0] ch;
    logic [CW-1:0]  div;
    logic [NCH-1:0] en;
    logic           sync;
    logic [NCH-1:0] et;
    logic           er;
  } vec_t;

  typedef struct {
    logic [NCH-1:0] t;
    logic           r;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge
  task automatic step(input string nm, input logic v, input int ch, input int div,
                      input logic [NCH-1:0] en, input logic sync,
                      input logic [NCH-1:0] et, input logic er);
    exp_t e;
    cfg_valid = v;
    cfg_ch    = CHW'(ch);
    cfg_div   = CW'(div);
    ch_en     = en;
    sync_req  = sync;
    sb.push_back('{t: et, r: er});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, " tick"}, 32'(tick), 32'(e.t));
    chk({nm, " ready"}, 32'(cfg_ready), 32'(e.r));
  endtask

  // Divisor write with all channels disabled
  task automatic wr(input string nm, input int ch, input int div);
    step({nm, " acc"}, 1'b1, ch, div, 4'b0000, 1'b0, 4'b0000, 1'b0);
    step({nm, " apl"}, 1'b0, 0, 0, 4'b0000, 1'b0, 4'b0000, 1'b1);
  endtask

  task automatic pushv(input logic v, input int ch, input int div, input logic [NCH-1:0] en,
                       input logic sync, input logic [NCH-1:0] et, input logic er);
    vecs.push_back('{v: v, ch: CHW'(ch), div: CW'(div), en: en, sync: sync, et: et, er: er});
  endtask

  initial begin
    logic [NCH-1:0] e;

    // D=4 on ch0, then D=0 and D=1 on ch1
    pushv(1'b1, 0, 4, 4'b0000, 1'b0, 4'b0000, 1'b0);
    pushv(1'b0, 0, 0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    for (int k = 1; k <= 12; k++) pushv(1'b0, 0, 0, 4'b0001, 1'b0, {3'b000, (k % 4) == 0}, 1'b1);
    pushv(1'b1, 1, 0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    pushv(1'b0, 0, 0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    for (int k = 1; k <= 5; k++) pushv(1'b0, 0, 0, 4'b0010, 1'b0, 4'b0010, 1'b1);
    pushv(1'b1, 1, 1, 4'b0010, 1'b0, 4'b0010, 1'b0);
    pushv(1'b0, 0, 0, 4'b0010, 1'b0, 4'b0000, 1'b1);
    for (int k = 1; k <= 5; k++) pushv(1'b0, 0, 0, 4'b0010, 1'b0, 4'b0010, 1'b1);

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; ch_en = '0; sync_req = 1'b0;
    #1;
    chk("reset tick", 32'(tick), 32'h0);
    chk("reset ready", 32'(cfg_ready), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].v, int'(vecs[i].ch), int'(vecs[i].div),
           vecs[i].en, vecs[i].sync, vecs[i].et, vecs[i].er);
    end

    // Freeze mid-count and resume from the held value
    wr("d5", 0, 5);
    for (int k = 1; k <= 2; k++) step("pre", 1'b0, 0, 0, 4'b0001, 1'b0, 4'b0000, 1'b1);
    for (int k = 1; k <= 10; k++) step("frz", 1'b0, 0, 0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    for (int k = 1; k <= 8; k++)
      step("resume", 1'b0, 0, 0, 4'b0001, 1'b0, {3'b000, (k == 3) || (k == 8)}, 1'b1);

    // Sync lands on ch0's wrap edge and must win
    wr("d3", 0, 3);
    wr("d7", 2, 7);
    for (int k = 1; k <= 5; k++)
      step("run2", 1'b0, 0, 0, 4'b0101, 1'b0, {3'b000, (k % 3) == 0}, 1'b1);
    step("sync", 1'b0, 0, 0, 4'b0101, 1'b1, 4'b0000, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      e = '0;
      e[0] = (k % 3) == 0;
      e[2] = (k == 7);
      step("postsync", 1'b0, 0, 0, 4'b0101, 1'b0, e, 1'b1);
    end

    // Back-to-back writes: second one waits out APPLY
    chk("b2b pre ready", 32'(cfg_ready), 32'h1);
    step("b2b w6", 1'b1, 3, 6, 4'b0000, 1'b0, 4'b0000, 1'b0);
    step("b2b hold", 1'b1, 3, 2, 4'b0000, 1'b0, 4'b0000, 1'b1);
    step("b2b w2", 1'b1, 3, 2, 4'b0000, 1'b0, 4'b0000, 1'b0);
    step("b2b apl", 1'b0, 0, 0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    for (int k = 1; k <= 6; k++)
      step("ch3", 1'b0, 0, 0, 4'b1000, 1'b0, {(k % 2) == 0, 3'b000}, 1'b1);

    // Reset during APPLY drops the pending D=8 write
    step("rstw", 1'b1, 0, 8, 4'b0010, 1'b0, 4'b0010, 1'b0);
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    ch_en = '0;
    #1;
    chk("mid rst tick", 32'(tick), 32'h0);
    chk("mid rst ready", 32'(cfg_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) step("dflt", 1'b0, 0, 0, 4'b0001, 1'b0, 4'b0000, 1'b1);

    // Sync coincident with APPLY: ch1 loads D=2 and every counter clears
    wr("s3", 0, 3);
    for (int k = 1; k <= 2; k++) step("sa pre", 1'b0, 0, 0, 4'b0001, 1'b0, 4'b0000, 1'b1);
    step("sa acc", 1'b1, 1, 2, 4'b0001, 1'b0, 4'b0001, 1'b0);
    step("sa both", 1'b0, 0, 0, 4'b0011, 1'b1, 4'b0000, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      e = '0;
      e[0] = (k % 3) == 0;
      e[1] = (k % 2) == 0;
      step("sa run", 1'b0, 0, 0, 4'b0011, 1'b0, e, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameters: NCH, default 4, number of tick channels.
REQ-002 Parameter: CW, default 20, width of each divisor register and counter.
REQ-003 Parameter: DEFAULT_DIV, default 524288, divisor loaded into every channel at reset.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: cfg_valid  input  1  requester presents a divisor write.
REQ-007 Port: cfg_ready  output  1  block accepts a write this cycle.
REQ-008 Port: cfg_ch  input  log2(NCH)  target channel of the write.
REQ-009 Port: cfg_div  input  CW  new divisor (tick period in clk cycles).
REQ-010 Port: ch_en  input  NCH  per-channel run enable.
REQ-011 Port: sync_req  input  1  realign all channel counters to zero.
REQ-012 Port: tick  output  NCH  per-channel single-cycle clock-enable pulse, registered.

Function
REQ-013 The block SHALL generate clock-enable pulses only; it SHALL NOT produce derived clocks.
REQ-014 Config FSM states: IDLE, APPLY; cfg_ready SHALL equal 1 exactly in IDLE.
REQ-015 IDLE -> APPLY when cfg_valid && cfg_ready; cfg_ch and cfg_div SHALL be captured on that edge.
REQ-016 APPLY -> IDLE unconditionally after one cycle; no write SHALL be accepted during APPLY.
REQ-017 In APPLY, the captured channel SHALL load div_reg with the captured divisor and clear its counter; its tick SHALL be 0 in the following cycle.
REQ-018 Effective divisor SHALL be max(div_reg, 1); a stored 0 SHALL behave as 1.
REQ-019 Per channel, while ch_en[i]=1, and neither sync nor APPLY targets it, the counter SHALL increment by 1 per cycle.
REQ-020 When the counter equals effective divisor - 1 on an enabled edge, it SHALL wrap to 0 and tick[i] SHALL be 1 for exactly the next cycle.
REQ-021 With divisor D and ch_en held high, tick period SHALL be exactly D cycles; first tick SHALL follow D enabled edges after counter = 0.
REQ-022 Effective divisor 1 SHALL give tick[i]=1 in every cycle following an enabled edge.
REQ-023 ch_en[i]=0 SHALL freeze the counter and force tick[i]=0 next cycle; re-enabling SHALL resume from the held count.
REQ-024 sync_req=1 SHALL clear all counters and suppress all ticks for the next cycle; it SHALL take priority over increment and wrap.
REQ-025 sync_req coincident with APPLY SHALL perform both: targeted divisor load and clearing of all counters.
REQ-026 Divisor writes SHALL NOT disturb counters or ticks of other channels.
REQ-027 If a divisor write lowers D below the current count, the cleared counter (REQ-017) SHALL prevent a missed wrap.
REQ-028 Counter arithmetic SHALL be CW bits unsigned; the counter SHALL never exceed effective divisor - 1.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, all counters=0, all div_reg=DEFAULT_DIV, tick=0.
REQ-030 On rst_n=0, cfg_ready SHALL read 1 once the state is IDLE.
REQ-031 Reset asserted mid-APPLY SHALL discard the pending write.
REQ-032 Release of rst_n SHALL be sampled synchronously; first counting edge is the first edge with rst_n=1.

Verification
REQ-033 Reset, write ch0 D=4, ch_en=0001 -> tick[0] high 1 cycle every 4 cycles; ticks 1-3 stay 0.
REQ-034 Write D=0 and D=1 to ch1, ch_en[1]=1 -> tick[1] high every cycle after first enabled edge, both cases.
REQ-035 ch0 D=5, drop ch_en[0] after count 2 for 10 cycles, re-enable -> next tick 3 enabled edges after re-enable.
REQ-036 ch0 D=3, ch2 D=7 running, pulse sync_req -> both counters 0, no tick next cycle, next ticks at +3 and +7.
REQ-037 Hold cfg_valid 2 cycles (ch3 D=6 then ch3 D=2) -> cfg_ready 1,0,1; second write accepted one cycle later; final period 2.
REQ-038 Assert rst_n=0 during APPLY of ch0 D=8 -> div_reg[0]=524288, tick=0, cfg_ready=1 after release.
